exec_stage: RTL and testbench
=============================

# exec_stage

Execute/writeback stage placed directly downstream of the 32-entry register file. Takes two operands read from the register file (read ports 1 and 2) plus an opcode and destination index. Computes an ALU result: single-cycle for logic/arith/shift, 32-cycle shift-add for multiply. Drives the register file write port (`data_in`, `write`, `write_sel`) with a registered, one-cycle write pulse.

## Interface

Parameters:

- `data_size`, 32, operand/result width; must match the register file width.

Ports:

- `dpclk` in 1: datapath clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `issue_valid` in 1: opcode/operands valid this cycle.
- `issue_ready` out 1: stage can accept an issue this cycle.
- `opcode` in 4: operation select.
- `dest_sel` in 5: destination register index.
- `src_a` in `data_size`: operand A (register file `data_out_1`).
- `src_b` in `data_size`: operand B (register file `data_out_2`).
- `wb_data` out `data_size`: result; connects to register file `data_in`.
- `wb_write` out 1: one-cycle write strobe; connects to `write`.
- `wb_sel` out 5: destination index; connects to `write_sel`.
- `flag_zero` out 1: last written result == 0.
- `flag_carry` out 1: carry/borrow of last ADD/SUB.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `busy` out 1: multiply in progress.

## Operation

- Opcodes:
  - 0 NOP
  - 1 ADD: a+b
  - 2 SUB: a−b
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SLL: a<<b[4:0]
  - 7 SRL: logical right shift
  - 8 SRA: arithmetic right shift
  - 9 PASSB: b
  - 10 MUL: low `data_size` bits of a*b, unsigned
  - 11–15 illegal
- Issue accepted when `issue_valid && issue_ready`; operands, opcode and `dest_sel` are captured on that edge.
- FSM states: IDLE, MUL.
  - IDLE: `issue_ready`=1.
  - Accepted single-cycle op: stays IDLE; result registered onto `wb_data`/`wb_sel` with `wb_write`=1 for the next cycle only.
  - Accepted MUL: goes to MUL; loads multiplicand, multiplier, accumulator=0 and counter=31.
  - MUL: `issue_ready`=0, `busy`=1. Each cycle: if multiplier[0], add multiplicand to accumulator; shift multiplicand left 1, multiplier right 1; decrement counter.
  - MUL exit: on the counter==0 cycle, go to IDLE and present the result with `wb_write`=1 the following cycle.
- NOP is accepted with no writeback and no flag change.
- Illegal opcode is accepted with no writeback and no flag change; `illegal_op`=1 for the cycle after acceptance.
- Flags update only in the same cycle as `wb_write`=1.
  - `flag_zero` = (`wb_data`==0).
  - `flag_carry` = bit `data_size` of the (`data_size`+1)-bit sum for ADD; borrow (a<b, unsigned) for SUB; 0 for all other ops.
- All arithmetic wraps modulo 2^`data_size`. Shift amounts ≥ `data_size` are impossible because only 5 bits are used.
- Destination index 0 is an ordinary register; no special handling.
- No forwarding or hazard detection. Upstream must not read a register in the cycle its write is pending.

## Timing

- Reset values: `issue_ready`=1, `wb_data`=0, `wb_write`=0, `wb_sel`=0, `flag_zero`=0, `flag_carry`=0, `illegal_op`=0, `busy`=0. FSM=IDLE, counter=0.
- Single-cycle latency: issue at edge N gives `wb_write` high during cycle N+1 and the register file is written at edge N+1. Throughput is 1 op/cycle.
- MUL latency: issue at edge N gives `wb_write` high during cycle N+33 (32 MUL cycles). `issue_ready` is low for cycles N+1..N+32.
- `issue_valid` with `issue_ready`=0 is ignored. Nothing is queued and inputs need not be held.
- `rst` during MUL aborts immediately: no writeback, all outputs return to reset values on that edge.
- `rst` with `issue_valid`=1 on the same edge: reset wins and the issue is dropped.
- `wb_data`/`wb_sel` hold their last value when `wb_write`=0.

## Configuration

- `EXEC_MUL_EN` defined: MUL state, counter and accumulator are compiled in; opcode 10 behaves as specified.
- `EXEC_MUL_EN` undefined: no MUL state, `busy` tied 0, and opcode 10 is treated as illegal (`illegal_op` pulse, no writeback).

## Test plan

- Reset: hold `rst` 2 cycles → all outputs at reset values, `issue_ready`=1.
- ADD back-to-back, dest 3 then 4:
  - 0xFFFFFFFF+1 → cycle after: `wb_write`=1, `wb_sel`=3, `wb_data`=0, `flag_zero`=1, `flag_carry`=1.
  - 5+7 next cycle → `wb_sel`=4, `wb_data`=12, `flag_carry`=0.
- SUB 3−5 → `wb_data`=0xFFFFFFFE, `flag_carry`=1.
- Shifts with `src_a`=0x80000000, `src_b`=0x24: SRA → 0xF8000000; SRL → 0x08000000.
- MUL 0x0001_0001 × 0x0000_FFFF (`EXEC_MUL_EN` defined):
  - `busy` high 32 cycles; issue attempts during those cycles are ignored.
  - `wb_write` rises exactly at cycle 33 with `wb_data`=0xFFFFFFFF.
- Reset at MUL cycle 10 → no `wb_write`, `issue_ready`=1 next cycle.
- Opcode 13 (and 10 without the macro) → `illegal_op` pulse, no `wb_write`, flags unchanged.

Source files
------------

// File: rtl/exec_if.sv
// ---------------------------------------------------------------------------
// exec_if
// Issue and writeback bundle between the issue logic, the exec_stage and
// the register file write port.
//
// Handshake: an issue transfers on a rising dpclk edge where issue_valid and
// issue_ready are both 1. Opcode, dest_sel, src_a and src_b are sampled on
// that edge only. When issue_ready is 0, issue_valid is ignored: nothing is
// queued and the issuer does not have to hold its inputs.
//
// Signals (master = issuer / register-file side, slave = exec_stage):
//   issue_valid  m->s  issue request this cycle
//   issue_ready  s->m  stage can accept an issue this cycle
//   opcode[3:0]  m->s  operation select
//   dest_sel[4:0] m->s destination register index
//   src_a, src_b m->s  operands (register file read ports 1 and 2)
//   wb_data      s->m  result, to register file data_in
//   wb_write     s->m  one-cycle write strobe, to register file write
//   wb_sel[4:0]  s->m  destination index, to register file write_sel
//   flag_zero    s->m  last written result was zero
//   flag_carry   s->m  carry/borrow of the last written ADD/SUB
//   illegal_op   s->m  one-cycle pulse after an unsupported opcode is accepted
//   busy         s->m  multiply in progress
// ---------------------------------------------------------------------------
interface exec_if #(
    parameter int data_size = 32
);
    logic                 issue_valid;
    logic                 issue_ready;
    logic [3:0]           opcode;
    logic [4:0]           dest_sel;
    logic [data_size-1:0] src_a;
    logic [data_size-1:0] src_b;
    logic [data_size-1:0] wb_data;
    logic                 wb_write;
    logic [4:0]           wb_sel;
    logic                 flag_zero;
    logic                 flag_carry;
    logic                 illegal_op;
    logic                 busy;

    modport master (
        output issue_valid, opcode, dest_sel, src_a, src_b,
        input  issue_ready, wb_data, wb_write, wb_sel,
               flag_zero, flag_carry, illegal_op, busy
    );

    modport slave (
        input  issue_valid, opcode, dest_sel, src_a, src_b,
        output issue_ready, wb_data, wb_write, wb_sel,
               flag_zero, flag_carry, illegal_op, busy
    );
endinterface

// File: rtl/exec_stage.sv
// ---------------------------------------------------------------------------
// exec_stage
// Execute/writeback stage sitting directly after the 32-entry register file.
// Single-cycle ALU ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, PASSB) write
// back one cycle after issue. MUL is an optional 32-step shift-add multiplier
// that writes back 33 cycles after issue.
//
// Build option:
//   EXEC_MUL_EN  defined   -> MUL state, counter and accumulator present,
//                             opcode 10 multiplies (low data_size bits).
//                undefined -> no MUL state, busy tied 0, opcode 10 is illegal.
//
// Ports:
//   dpclk      datapath clock, rising edge
//   rst        synchronous active-high reset
//   bus        exec_if.slave: issue handshake, operands, writeback, flags
//   state_dbg  current FSM state (0 = IDLE, 1 = MUL) for observation
// ---------------------------------------------------------------------------
module exec_stage #(
    parameter int data_size = 32
) (
    input  logic   dpclk,
    input  logic   rst,
    exec_if.slave  bus,
    output logic   state_dbg
);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t               state;
    logic [data_size-1:0] wb_data_r;
    logic                 wb_write_r;
    logic [4:0]           wb_sel_r;
    logic                 flag_zero_r;
    logic                 flag_carry_r;
    logic                 illegal_op_r;

    // Decode / single-cycle ALU (combinational on the issue inputs)
    logic [data_size:0]   add_ext;
    logic [data_size-1:0] alu_result;
    logic                 alu_carry;
    logic                 op_wb;
    logic                 op_illegal;
    logic                 op_mul;
    logic [4:0]           shamt;

    always_comb begin
        add_ext    = {1'b0, bus.src_a} + {1'b0, bus.src_b};
        shamt      = bus.src_b[4:0];
        alu_result = '0;
        alu_carry  = 1'b0;
        op_wb      = 1'b1;
        op_illegal = 1'b0;
        op_mul     = 1'b0;
        case (bus.opcode)
            OP_NOP:   op_wb = 1'b0;
            OP_ADD: begin
                alu_result = add_ext[data_size-1:0];
                alu_carry  = add_ext[data_size];
            end
            OP_SUB: begin
                alu_result = bus.src_a - bus.src_b;
                alu_carry  = (bus.src_a < bus.src_b);   // unsigned borrow
            end
            OP_AND:   alu_result = bus.src_a & bus.src_b;
            OP_OR:    alu_result = bus.src_a | bus.src_b;
            OP_XOR:   alu_result = bus.src_a ^ bus.src_b;
            OP_SLL:   alu_result = bus.src_a << shamt;
            OP_SRL:   alu_result = bus.src_a >> shamt;
            OP_SRA:   alu_result = $unsigned($signed(bus.src_a) >>> shamt);
            OP_PASSB: alu_result = bus.src_b;
`ifdef EXEC_MUL_EN
            OP_MUL: begin
                op_wb  = 1'b0;
                op_mul = 1'b1;
            end
`else
            OP_MUL: begin
                op_wb      = 1'b0;
                op_illegal = 1'b1;
            end
`endif
            default: begin
                op_wb      = 1'b0;
                op_illegal = 1'b1;
            end
        endcase
    end

`ifdef EXEC_MUL_EN
    logic [data_size-1:0] mul_mcand;
    logic [data_size-1:0] mul_mplier;
    logic [data_size-1:0] mul_acc;
    logic [data_size-1:0] mul_acc_next;
    logic [4:0]           mul_count;
    logic [4:0]           mul_dest;

    // One shift-add step; on the last step this value is the final product.
    always_comb begin
        mul_acc_next = mul_acc;
        if (mul_mplier[0]) begin
            mul_acc_next = mul_acc + mul_mcand;
        end
    end
`endif

    always_ff @(posedge dpclk) begin
        if (rst) begin
            state        <= ST_IDLE;
            wb_data_r    <= '0;
            wb_write_r   <= 1'b0;
            wb_sel_r     <= '0;
            flag_zero_r  <= 1'b0;
            flag_carry_r <= 1'b0;
            illegal_op_r <= 1'b0;
`ifdef EXEC_MUL_EN
            mul_mcand    <= '0;
            mul_mplier   <= '0;
            mul_acc      <= '0;
            mul_count    <= '0;
            mul_dest     <= '0;
`endif
        end else begin
            // Strobes are single-cycle by default.
            wb_write_r   <= 1'b0;
            illegal_op_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.issue_valid) begin
                        if (op_wb) begin
                            wb_data_r    <= alu_result;
                            wb_sel_r     <= bus.dest_sel;
                            wb_write_r   <= 1'b1;
                            flag_zero_r  <= (alu_result == '0);
                            flag_carry_r <= alu_carry;
                        end
                        if (op_illegal) begin
                            illegal_op_r <= 1'b1;
                        end
`ifdef EXEC_MUL_EN
                        if (op_mul) begin
                            state      <= ST_MUL;
                            mul_mcand  <= bus.src_a;
                            mul_mplier <= bus.src_b;
                            mul_acc    <= '0;
                            mul_count  <= 5'd31;
                            mul_dest   <= bus.dest_sel;
                        end
`endif
                    end
                end
`ifdef EXEC_MUL_EN
                ST_MUL: begin
                    mul_acc    <= mul_acc_next;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    if (mul_count == 5'd0) begin
                        state        <= ST_IDLE;
                        wb_data_r    <= mul_acc_next;
                        wb_sel_r     <= mul_dest;
                        wb_write_r   <= 1'b1;
                        flag_zero_r  <= (mul_acc_next == '0);
                        flag_carry_r <= 1'b0;
                    end else begin
                        mul_count <= mul_count - 5'd1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Unused in single-cycle-only builds.
    logic unused_mul_flag;
    assign unused_mul_flag = op_mul;

    assign bus.issue_ready = (state == ST_IDLE);
`ifdef EXEC_MUL_EN
    assign bus.busy        = (state == ST_MUL);
`else
    assign bus.busy        = 1'b0;
`endif
    assign bus.wb_data     = wb_data_r;
    assign bus.wb_write    = wb_write_r;
    assign bus.wb_sel      = wb_sel_r;
    assign bus.flag_zero   = flag_zero_r;
    assign bus.flag_carry  = flag_carry_r;
    assign bus.illegal_op  = illegal_op_r;
    assign state_dbg       = state;

endmodule

// File: tb/tb_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_exec_stage
// Directed bench for exec_stage. Inputs change on the falling edge, outputs
// are checked on the following falling edge, i.e. during the cycle after the
// rising edge that captured the issue.
// ---------------------------------------------------------------------------
module tb_exec_stage;
    localparam int DS = 32;

    logic dpclk = 1'b0;
    logic rst   = 1'b1;
    logic state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    exec_if #(.data_size(DS)) bus ();

    exec_stage #(.data_size(DS)) dut (
        .dpclk     (dpclk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 dpclk = ~dpclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] dest,
                         input logic [31:0] a, input logic [31:0] b);
        bus.issue_valid = 1'b1;
        bus.opcode      = op;
        bus.dest_sel    = dest;
        bus.src_a       = a;
        bus.src_b       = b;
    endtask

    task automatic idle_in();
        bus.issue_valid = 1'b0;
        bus.opcode      = 4'd0;
        bus.dest_sel    = 5'd0;
        bus.src_a       = '0;
        bus.src_b       = '0;
    endtask

    task automatic step();
        @(negedge dpclk);
    endtask

    task automatic check_wb(input string tag, input logic [4:0] sel, input logic [31:0] data,
                            input logic zero, input logic carry);
        check({tag, "_write"}, {31'd0, bus.wb_write}, 32'd1);
        check({tag, "_sel"},   {27'd0, bus.wb_sel}, {27'd0, sel});
        check({tag, "_data"},  bus.wb_data, data);
        check({tag, "_zero"},  {31'd0, bus.flag_zero}, {31'd0, zero});
        check({tag, "_carry"}, {31'd0, bus.flag_carry}, {31'd0, carry});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, bus.issue_ready}, 32'd1);
        check({tag, "_data"},  bus.wb_data, 32'd0);
        check({tag, "_write"}, {31'd0, bus.wb_write}, 32'd0);
        check({tag, "_sel"},   {27'd0, bus.wb_sel}, 32'd0);
        check({tag, "_zero"},  {31'd0, bus.flag_zero}, 32'd0);
        check({tag, "_carry"}, {31'd0, bus.flag_carry}, 32'd0);
        check({tag, "_ill"},   {31'd0, bus.illegal_op}, 32'd0);
        check({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
        check({tag, "_state"}, {31'd0, state_dbg}, 32'd0);
    endtask

    initial begin
        idle_in();

        // Reset held for two cycles.
        rst = 1'b1;
        step();
        step();
        check_reset_outputs("rst");
        rst = 1'b0;

        // ADD back-to-back: carry out with zero result, then a plain add.
        drive(4'd1, 5'd3, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        check_wb("add1", 5'd3, 32'h0000_0000, 1'b1, 1'b1);
        drive(4'd1, 5'd4, 32'd5, 32'd7);
        step();
        check_wb("add2", 5'd4, 32'd12, 1'b0, 1'b0);
        idle_in();
        step();
        // No issue: strobe drops, data/sel hold.
        check("hold_write", {31'd0, bus.wb_write}, 32'd0);
        check("hold_data",  bus.wb_data, 32'd12);
        check("hold_sel",   {27'd0, bus.wb_sel}, 32'd4);

        // SUB with borrow.
        drive(4'd2, 5'd7, 32'd3, 32'd5);
        step();
        check_wb("sub", 5'd7, 32'hFFFF_FFFE, 1'b0, 1'b1);

        // Shifts: only src_b[4:0] is the amount (0x24 -> 4).
        drive(4'd8, 5'd1, 32'h8000_0000, 32'h0000_0024);
        step();
        check_wb("sra", 5'd1, 32'hF800_0000, 1'b0, 1'b0);
        drive(4'd7, 5'd2, 32'h8000_0000, 32'h0000_0024);
        step();
        check_wb("srl", 5'd2, 32'h0800_0000, 1'b0, 1'b0);
        drive(4'd6, 5'd5, 32'h8000_0001, 32'h0000_0021);
        step();
        check_wb("sll", 5'd5, 32'h0000_0002, 1'b0, 1'b0);

        // Logic ops and PASSB.
        drive(4'd3, 5'd6, 32'h0000_F0F0, 32'h0000_FF00);
        step();
        check_wb("and", 5'd6, 32'h0000_F000, 1'b0, 1'b0);
        drive(4'd4, 5'd8, 32'h0000_F0F0, 32'h0000_FF00);
        step();
        check_wb("or", 5'd8, 32'h0000_FFF0, 1'b0, 1'b0);
        drive(4'd5, 5'd9, 32'h0000_F0F0, 32'h0000_FF00);
        step();
        check_wb("xor", 5'd9, 32'h0000_0FF0, 1'b0, 1'b0);
        drive(4'd9, 5'd0, 32'h1234_5678, 32'hCAFE_BABE);
        step();
        check_wb("passb", 5'd0, 32'hCAFE_BABE, 1'b0, 1'b0);

        // Set both flags, then NOP and illegal must leave them alone.
        drive(4'd1, 5'd10, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        check_wb("add3", 5'd10, 32'h0000_0000, 1'b1, 1'b1);
        drive(4'd0, 5'd11, 32'd1, 32'd2);
        step();
        check("nop_write", {31'd0, bus.wb_write}, 32'd0);
        check("nop_ill",   {31'd0, bus.illegal_op}, 32'd0);
        check("nop_zero",  {31'd0, bus.flag_zero}, 32'd1);
        check("nop_carry", {31'd0, bus.flag_carry}, 32'd1);
        check("nop_sel",   {27'd0, bus.wb_sel}, 32'd10);
        drive(4'd13, 5'd12, 32'd1, 32'd2);
        step();
        check("ill13_pulse", {31'd0, bus.illegal_op}, 32'd1);
        check("ill13_write", {31'd0, bus.wb_write}, 32'd0);
        check("ill13_zero",  {31'd0, bus.flag_zero}, 32'd1);
        check("ill13_carry", {31'd0, bus.flag_carry}, 32'd1);
        idle_in();
        step();
        check("ill13_end", {31'd0, bus.illegal_op}, 32'd0);

`ifdef EXEC_MUL_EN
        // MUL: 32 busy cycles, competing issues ignored, result on cycle 33.
        drive(4'd10, 5'd9, 32'h0001_0001, 32'h0000_FFFF);
        step();
        drive(4'd1, 5'd3, 32'd1, 32'd1);
        for (int k = 1; k <= 32; k++) begin
            check("mul_busy",  {31'd0, bus.busy}, 32'd1);
            check("mul_ready", {31'd0, bus.issue_ready}, 32'd0);
            check("mul_nowb",  {31'd0, bus.wb_write}, 32'd0);
            if (k == 32) idle_in();
            step();
        end
        check_wb("mul", 5'd9, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("mul_done_busy", {31'd0, bus.busy}, 32'd0);
        step();
        check("mul_after_write", {31'd0, bus.wb_write}, 32'd0);

        // Reset during MUL cycle 10 aborts with no writeback.
        drive(4'd10, 5'd2, 32'd3, 32'd4);
        step();
        idle_in();
        for (int k = 1; k < 10; k++) step();
        check("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("abort");
        begin
            int writes;
            writes = 0;
            for (int k = 0; k < 30; k++) begin
                if (bus.wb_write) writes++;
                step();
            end
            check("abort_no_wb", writes, 32'd0);
        end
`else
        // Without the multiplier, opcode 10 is illegal.
        drive(4'd10, 5'd9, 32'h0001_0001, 32'h0000_FFFF);
        step();
        idle_in();
        check("ill10_pulse", {31'd0, bus.illegal_op}, 32'd1);
        check("ill10_write", {31'd0, bus.wb_write}, 32'd0);
        check("ill10_busy",  {31'd0, bus.busy}, 32'd0);
        check("ill10_ready", {31'd0, bus.issue_ready}, 32'd1);
        check("ill10_zero",  {31'd0, bus.flag_zero}, 32'd1);
        step();
        check("ill10_end", {31'd0, bus.illegal_op}, 32'd0);
`endif

        // Write something nonzero, then reset together with an issue: reset wins.
        drive(4'd9, 5'd17, 32'd0, 32'h0000_00AA);
        step();
        check_wb("pre_rst", 5'd17, 32'h0000_00AA, 1'b0, 1'b0);
        drive(4'd1, 5'd18, 32'd1, 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_in();
        check_reset_outputs("rst_issue");
        step();
        check("rst_issue_late", {31'd0, bus.wb_write}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
